// File: rtl/genius_pkg.sv
// genius_pkg
// Shared definitions for the Genius game datapath: symbol and pattern-index
// widths, the highest playable level, the symbol encodings and the state
// encoding used by the sequence player.
// No ports (package).
package genius_pkg;

  localparam int SYM_W     = 2;
  localparam int IDX_W     = 4;
  localparam int MAX_LEVEL = (1 << IDX_W) - 1;

  localparam logic [SYM_W-1:0] SYM_0 = SYM_W'(0);
  localparam logic [SYM_W-1:0] SYM_1 = SYM_W'(1);
  localparam logic [SYM_W-1:0] SYM_2 = SYM_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ON,
    ST_GAP,
    ST_DONE
  } player_state_e;

  // Used to size the shared on/gap timer from the larger of the two periods.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sequence_player_cycle_timer.sv
// cycle_timer
// Loadable down-counter used to time the on and gap phases of playback.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low
//   load_i        in   load load_value_i into the counter (wins over enable_i)
//   load_value_i  in   W  value to load
//   enable_i      in   count down while high
//   expired_o     out  high in the last counted cycle (count==1 with enable)
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         enable_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Saturate at zero so an idle enabled timer never wraps around.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == W'(1));

endmodule

// File: rtl/sequence_player.sv
// sequence_player
// Timed playback controller for the Genius game. On start it walks the
// stored pattern from index 0 up to the latched level, fetching each symbol,
// showing it for ON_CYCLES and blanking the display for GAP_CYCLES.
// Optional feature macro: SEQ_PLAYER_PAUSE_EN adds a pause input that
// freezes the ON and GAP phases while held high.
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-low
//   start       in   playback request, only honoured in IDLE
//   abort       in   cancel playback, back to IDLE without done
//   pause       in   (SEQ_PLAYER_PAUSE_EN only) freeze timer in ON/GAP
//   level       in   IDX_W  last index to play, latched on start
//   sym         in   SYM_W  symbol read from pattern storage
//   seq_index   out  IDX_W  pattern storage address
//   show_valid  out  display enable
//   show_sym    out  SYM_W  symbol to display
//   busy        out  high whenever not IDLE
//   done        out  one-cycle pulse at the end of playback
module sequence_player
  import genius_pkg::*;
#(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000,
  parameter int IDX_W      = genius_pkg::IDX_W,
  parameter int SYM_W      = genius_pkg::SYM_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef SEQ_PLAYER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [IDX_W-1:0] level,
  input  logic [SYM_W-1:0] sym,
  output logic [IDX_W-1:0] seq_index,
  output logic             show_valid,
  output logic [SYM_W-1:0] show_sym,
  output logic             busy,
  output logic             done
);

  localparam int TW = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);

  player_state_e    state_q;
  logic [IDX_W-1:0] lvl_q;
  logic [IDX_W-1:0] seq_index_q;
  logic             show_valid_q;
  logic [SYM_W-1:0] show_sym_q;
  logic             busy_q;
  logic             done_q;

  logic             run;
  logic             timer_load;
  logic [TW-1:0]    timer_load_value;
  logic             timer_enable;
  logic             timer_expired;

`ifdef SEQ_PLAYER_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  // The timer only counts in the two timed phases; the ON period is armed as
  // FETCH exits and the GAP period is armed on the same edge ON expires.
  assign timer_enable     = ((state_q == ST_ON) || (state_q == ST_GAP)) && run;
  assign timer_load       = (state_q == ST_FETCH) || ((state_q == ST_ON) && timer_expired);
  assign timer_load_value = (state_q == ST_FETCH) ? TW'(ON_CYCLES) : TW'(GAP_CYCLES);

  cycle_timer #(
    .W(TW)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .load_i      (timer_load),
    .load_value_i(timer_load_value),
    .enable_i    (timer_enable),
    .expired_o   (timer_expired)
  );

  // Playback FSM with all outputs registered. abort is checked ahead of the
  // per-state work so it wins over start, pause and timer expiry; seq_index
  // deliberately keeps its value on abort.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lvl_q        <= '0;
      seq_index_q  <= '0;
      show_valid_q <= 1'b0;
      show_sym_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            lvl_q       <= level;
            seq_index_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            show_sym_q   <= sym;
            show_valid_q <= 1'b1;
            state_q      <= ST_ON;
          end
        end
        ST_ON: begin
          if (abort) begin
            show_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (timer_expired) begin
            show_valid_q <= 1'b0;
            state_q      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (timer_expired) begin
            if (seq_index_q == lvl_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              seq_index_q <= seq_index_q + 1'b1;
              state_q     <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          show_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign seq_index  = seq_index_q;
  assign show_valid = show_valid_q;
  assign show_sym   = show_sym_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player
// Directed bench for sequence_player with ON=3, GAP=2 (6 cycles per
// element) and a pattern storage model. Cycle c counts from the start edge:
// c=1 is the FETCH cycle of element 0.
// Define SEQ_PLAYER_PAUSE_EN to also exercise the pause input.
module tb_sequence_player;
  import genius_pkg::*;

  localparam int ON  = 3;
  localparam int GAP = 2;
  localparam int P   = 1 + ON + GAP;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
`ifdef SEQ_PLAYER_PAUSE_EN
  logic             pause = 1'b0;
`endif
  logic [IDX_W-1:0] level = '0;
  logic [SYM_W-1:0] sym;
  logic [IDX_W-1:0] seq_index;
  logic             show_valid;
  logic [SYM_W-1:0] show_sym;
  logic             busy;
  logic             done;

  logic [SYM_W-1:0] rom [16];

  int checks = 0;
  int fails  = 0;

  sequence_player #(
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .IDX_W     (IDX_W),
    .SYM_W     (SYM_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
`ifdef SEQ_PLAYER_PAUSE_EN
    .pause     (pause),
`endif
    .level     (level),
    .sym       (sym),
    .seq_index (seq_index),
    .show_valid(show_valid),
    .show_sym  (show_sym),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Pattern storage: the addressed symbol arrives within the cycle the
  // address is presented, in time for FETCH to capture it.
  always @(negedge clock) sym <= rom[seq_index];

  typedef struct {
    logic             start;
    logic [IDX_W-1:0] lvl;
    logic [IDX_W-1:0] expIdx;
    logic             expSv;
    logic             expBusy;
    logic             expDone;
    logic             chkSym;
    logic [SYM_W-1:0] expSym;
  } vec_t;

  vec_t t1 [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [IDX_W-1:0] l);
    start = s;
    abort = a;
    level = l;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Reference timeline for an uninterrupted playback of levels 0..L.
  task automatic checkModel(input string tag, input int c, input int L);
    int total;
    int k;
    int ph;
    int eIdx;
    logic eSv;
    logic eBusy;
    logic eDone;
    logic [SYM_W-1:0] eSym;
    logic chkSym;
    total  = (L + 1) * P;
    chkSym = 1'b1;
    eSym   = '0;
    if (c <= total) begin
      k     = (c - 1) / P;
      ph    = (c - 1) % P;
      eIdx  = k;
      eSv   = (ph >= 1) && (ph <= ON);
      eBusy = 1'b1;
      eDone = 1'b0;
      if (ph >= 1) eSym = rom[k];
      else if (k > 0) eSym = rom[k - 1];
      else chkSym = 1'b0;
    end else begin
      eIdx  = L;
      eSv   = 1'b0;
      eBusy = (c == total + 1);
      eDone = (c == total + 1);
      eSym  = rom[L];
    end
    checkOutput($sformatf("%s c%0d seq_index", tag, c), 32'(seq_index), 32'(eIdx));
    checkOutput($sformatf("%s c%0d show_valid", tag, c), 32'(show_valid), 32'(eSv));
    checkOutput($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(eBusy));
    checkOutput($sformatf("%s c%0d done", tag, c), 32'(done), 32'(eDone));
    if (chkSym) checkOutput($sformatf("%s c%0d show_sym", tag, c), 32'(show_sym), 32'(eSym));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " seq_index"}, 32'(seq_index), 32'd0);
    checkOutput({tag, " show_valid"}, 32'(show_valid), 32'd0);
    checkOutput({tag, " show_sym"}, 32'(show_sym), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rom = '{SYM_2, SYM_1, SYM_0, SYM_1, SYM_2, SYM_0, SYM_1, SYM_2,
            SYM_0, SYM_1, SYM_2, SYM_0, SYM_1, SYM_2, SYM_0, 2'd3};

    // Test 1 vectors: level 0, one element, rom[0]=2.
    t1[0] = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    t1[1] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    t1[2] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    t1[3] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    t1[4] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    t1[5] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    t1[6] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
    t1[7] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};

    // Reset state.
    stepCycle();
    stepCycle();
    checkResetValues("reset");
    reset = 1'b1;
    stepCycle();

    // Test 1: table-driven single element.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(t1[i].start, 1'b0, t1[i].lvl);
      checkOutput($sformatf("t1 v%0d seq_index", i), 32'(seq_index), 32'(t1[i].expIdx));
      checkOutput($sformatf("t1 v%0d show_valid", i), 32'(show_valid), 32'(t1[i].expSv));
      checkOutput($sformatf("t1 v%0d busy", i), 32'(busy), 32'(t1[i].expBusy));
      checkOutput($sformatf("t1 v%0d done", i), 32'(done), 32'(t1[i].expDone));
      if (t1[i].chkSym) checkOutput($sformatf("t1 v%0d show_sym", i), 32'(show_sym), 32'(t1[i].expSym));
    end

    // Test 2: level 3, level input changed mid-playback.
    applyStimulus(1'b1, 1'b0, 4'd3);
    checkModel("t2", 1, 3);
    for (int c = 2; c <= 4 * P + 2; c++) begin
      applyStimulus(1'b0, 1'b0, (c >= 5) ? 4'd0 : 4'd3);
      checkModel("t2", c, 3);
    end

    // Test 3: abort during ON of element 2, then a fresh start.
    applyStimulus(1'b1, 1'b0, 4'd5);
    checkModel("t3", 1, 5);
    for (int c = 2; c <= 14; c++) begin
      applyStimulus(1'b0, 1'b0, 4'd5);
      checkModel("t3", c, 5);
    end
    applyStimulus(1'b0, 1'b1, 4'd5);
    checkOutput("t3 abort show_valid", 32'(show_valid), 32'd0);
    checkOutput("t3 abort busy", 32'(busy), 32'd0);
    checkOutput("t3 abort seq_index", 32'(seq_index), 32'd2);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b0, 4'd5);
      checkOutput($sformatf("t3 post-abort %0d done", c), 32'(done), 32'd0);
      checkOutput($sformatf("t3 post-abort %0d busy", c), 32'(busy), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 4'd5);
    checkModel("t3 restart", 1, 5);
    applyStimulus(1'b0, 1'b0, 4'd5);
    checkModel("t3 restart", 2, 5);
    applyStimulus(1'b0, 1'b1, 4'd5);
    checkOutput("t3 second abort busy", 32'(busy), 32'd0);

    // Test 4: maximum level, no wrap, stray start ignored.
    applyStimulus(1'b1, 1'b0, 4'd15);
    checkModel("t4", 1, 15);
    for (int c = 2; c <= 16 * P + 2; c++) begin
      applyStimulus(c == 10, 1'b0, 4'd15);
      checkModel("t4", c, 15);
    end

    // Test 5: reset mid-GAP of element 1, then start+abort together.
    applyStimulus(1'b1, 1'b0, 4'd3);
    for (int c = 2; c <= 11; c++) applyStimulus(1'b0, 1'b0, 4'd3);
    checkModel("t5 pre-reset", 11, 3);
    reset = 1'b0;
    stepCycle();
    checkResetValues("t5 reset");
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd3);
    checkOutput("t5 start+abort busy", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("t5 start+abort busy later", 32'(busy), 32'd0);
    checkOutput("t5 start+abort seq_index", 32'(seq_index), 32'd0);

`ifdef SEQ_PLAYER_PAUSE_EN
    // Test 6: pause held four cycles during ON of element 0.
    applyStimulus(1'b1, 1'b0, 4'd0);
    for (int c = 2; c <= 12; c++) begin
      pause = (c >= 3) && (c <= 6);
      applyStimulus(1'b0, 1'b0, 4'd0);
      checkOutput($sformatf("t6 c%0d show_valid", c), 32'(show_valid), 32'((c >= 2) && (c <= 8)));
      checkOutput($sformatf("t6 c%0d done", c), 32'(done), 32'(c == 11));
      checkOutput($sformatf("t6 c%0d busy", c), 32'(busy), 32'(c <= 11));
    end
    pause = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
# sequence_player

Timed playback controller for the Genius game. On a start request it walks the stored pattern from index 0 up to the current level. For each element it fetches the symbol from the pattern storage, holds it on the display for a fixed on-time, then blanks it for a gap. It sits between the game FSM, which issues start/abort and reads done, and the pattern storage plus the 7-segment/LED display path.

## Interface
- ON_CYCLES, 25_000_000, clock cycles each symbol is shown (≥1)
- GAP_CYCLES, 12_500_000, clock cycles of blank display between symbols (≥1)
- IDX_W, 4, pattern index width; max level = 2^IDX_W−1
- SYM_W, 2, symbol width
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  request playback; sampled only in IDLE
- abort  in  1  cancel playback, return to IDLE
- level  in  IDX_W  last index to play (inclusive); latched on accepted start
- sym  in  SYM_W  symbol from pattern storage, valid 1 cycle after seq_index
- seq_index  out  IDX_W  address to pattern storage
- show_valid  out  1  display enable for show_sym
- show_sym  out  SYM_W  symbol to display
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when playback completes

## Operation
- States: IDLE, FETCH, ON, GAP, DONE.
- IDLE: when start=1 and abort=0, latch level into lvl_q, set seq_index=0, go to FETCH. start while busy is ignored.
- FETCH (1 cycle): seq_index stable; at exit, capture sym into show_sym and load the timer with ON_CYCLES; go to ON.
- ON: show_valid=1; when the timer expires, load GAP_CYCLES and go to GAP.
- GAP: show_valid=0. On expiry: if seq_index==lvl_q go to DONE; otherwise seq_index+1 and go to FETCH.
- DONE (1 cycle): done=1, then go to IDLE.
- seq_index never wraps. Index 2^IDX_W−1 is the final element when level is at its maximum.
- abort=1 in any non-IDLE state: next state is IDLE, show_valid=0, no done pulse. seq_index holds its value. abort in IDLE outranks a simultaneous start, so the start is dropped.
- Changes to level during playback have no effect.
- show_sym holds its last value while show_valid=0.

## Timing
- Reset values: seq_index=0, show_valid=0, show_sym=0, busy=0, done=0, state IDLE, timer 0.
- Start sampled at edge t0. FETCH runs at t0+1 and show_valid first goes high at t0+2.
- Each element takes 1+ON_CYCLES+GAP_CYCLES cycles.
- For element k: FETCH at t0+1+k·P, with P=1+ON_CYCLES+GAP_CYCLES.
- done is high during cycle t0+1+(level+1)·P. busy drops in the following cycle.
- A new start is accepted in the first IDLE cycle after DONE.
- reset low at any point forces reset values at the next edge. It outranks abort, start and pause.

## Configuration
- SEQ_PLAYER_PAUSE_EN defined: adds port pause (in, 1).
  - While pause=1 in ON or GAP, the timer and state freeze and show_valid keeps its value.
  - FETCH and DONE are not frozen.
  - abort still acts immediately.
- Undefined: no pause port; the timer always runs.

## Structure
- Shared package genius_pkg holds:
  - SYM_W, IDX_W and MAX_LEVEL
  - symbol constants SYM_0=0, SYM_1=1, SYM_2=2
  - the player state enum
- One sub-module, cycle_timer: a loadable down-counter with load, enable and expired outputs.
  - Width is $clog2(max(ON_CYCLES,GAP_CYCLES)+1).
  - expired is asserted when the count reaches 1 with enable high.

## Test plan
Common bench setup: ON=3, GAP=2 (P=6), and a pattern ROM model with 1-cycle latency.

1. level=0, start at t0 -> seq_index=0 at t0+1; show_valid high t0+2..t0+4, low t0+5..t0+6; done at t0+7; busy low at t0+8.
2. level=3, ROM {2,1,0,1} -> show_sym 2,1,0,1, each shown 3 cycles; done at t0+25; level changed to 0 at t0+5 is ignored.
3. Abort during ON of element 2 (level=5) -> next cycle show_valid=0 and busy=0, no done. A fresh start replays from index 0.
4. level=15 -> seq_index steps 0..15 without wrapping; done at t0+97. A start pulse at t0+10 has no effect.
5. reset driven low mid-GAP of element 1 -> all outputs at reset values after one edge. Simultaneous start+abort in IDLE leaves busy=0.
6. With SEQ_PLAYER_PAUSE_EN: pause high 4 cycles during ON of element 0, level=0 -> show_valid high 7 cycles; done at t0+11.
